tt_dfd_pipe_dff_clr: RTL and testbench

- Parametrised DEPTH-stage valid/ready pipeline register with synchronous flush. It is the multi-stage successor to the single enable/clear flop.
- Used on DFD trace and debug datapaths that need retiming across several stages while honouring downstream backpressure and a global flush.
- Each stage holds a valid bit and a WIDTH-bit payload. COLLAPSE mode selects bubble-collapsing stages or lock-step stall.

---
 rtl/tt_dfd_pkg.sv | 6 +
 rtl/tt_dfd_generic_dff_clr.sv | 18 +
 rtl/tt_dfd_pipe_stage.sv | 23 ++
 rtl/tt_dfd_pipe_dff_clr.sv | 62 ++++++
 tb/tb_tt_dfd_pipe_dff_clr.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_dfd_pkg.sv
// tt_dfd_pkg: shared helpers for the DFD pipe and FIFO blocks
package tt_dfd_pkg;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/tt_dfd_generic_dff_clr.sv
// tt_dfd_generic_dff_clr: enable flop with synchronous clear and async reset
module tt_dfd_generic_dff_clr #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  // clear beats enable; flop holds when neither is set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_q <= RESET_VALUE;
    else if (i_clr) o_q <= RESET_VALUE;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/tt_dfd_pipe_stage.sv
// tt_dfd_pipe_stage: one valid bit plus payload; payload only loads on valid source
module tt_dfd_pipe_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic             i_src_vld,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);
  tt_dfd_generic_dff_clr #(.WIDTH(1), .RESET_VALUE(1'b0)) u_vld (
    .clk(clk), .rst_n(rst_n), .i_en(i_adv), .i_clr(i_clr),
    .i_d(i_src_vld), .o_q(o_vld)
  );
  tt_dfd_generic_dff_clr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_data (
    .clk(clk), .rst_n(rst_n), .i_en(i_adv & i_src_vld), .i_clr(i_clr),
    .i_d(i_src_data), .o_q(o_data)
  );
endmodule

// File: rtl/tt_dfd_pipe_dff_clr.sv
// tt_dfd_pipe_dff_clr: DEPTH-stage valid/ready pipeline with flush and occupancy
module tt_dfd_pipe_dff_clr import tt_dfd_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit COLLAPSE = 1'b1,
  parameter int CNT_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occ
);
  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_vld;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_occ;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (COLLAPSE) begin : g_col
      assign w_adv[i] = out_rdy | ~&w_vld[DEPTH-1:i];
    end else begin : g_lock
      assign w_adv[i] = out_rdy | ~w_vld[DEPTH-1];
    end
    if (i == 0) begin : g_src_in
      assign w_src_vld[i]  = in_vld;
      assign w_src_data[i] = in_data;
    end else begin : g_src_prev
      assign w_src_vld[i]  = w_vld[i-1];
      assign w_src_data[i] = w_data[i-1];
    end
    tt_dfd_pipe_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
      .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_adv(w_adv[i]),
      .i_src_vld(w_src_vld[i]), .i_src_data(w_src_data[i]),
      .o_vld(w_vld[i]), .o_data(w_data[i])
    );
  end
  assign in_rdy     = w_adv[0] & ~clr;
  assign out_vld    = w_vld[DEPTH-1] & ~clr;
  assign out_data   = w_data[DEPTH-1];
  assign w_in_fire  = in_vld & in_rdy;
  assign w_out_fire = out_vld & out_rdy;
  assign occ        = r_occ;
  // occupancy tracks completed handshakes; flush empties it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_occ <= '0;
    else r_occ <= clr ? '0 : r_occ + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) r_occ <= CNT_W'(DEPTH));
  a_occ_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_in_fire && !w_out_fire && r_occ == CNT_W'(DEPTH)));
  a_occ_unf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_out_fire && !w_in_fire && r_occ == '0));
endmodule

// File: tb/tb_tt_dfd_pipe_dff_clr.sv
// tb_tt_dfd_pipe_dff_clr: scoreboard bench for collapsing, lock-step and single-stage pipes
module tb_tt_dfd_pipe_dff_clr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_clr = 0, a_in_vld = 0, a_in_rdy, a_out_vld, a_out_rdy = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [1:0] a_occ;
  logic b_clr = 0, b_in_vld = 0, b_in_rdy, b_out_vld, b_out_rdy = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [1:0] b_occ;
  logic c_clr = 0, c_in_vld = 0, c_in_rdy, c_out_vld, c_out_rdy = 0;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [0:0] c_occ;
  int n_tests = 0;
  int n_fail = 0;
  int a_pops = 0;
  logic [7:0] a_q [$];
  tt_dfd_pipe_dff_clr #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5), .COLLAPSE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .in_data(a_in_data), .out_vld(a_out_vld), .out_rdy(a_out_rdy),
    .out_data(a_out_data), .occ(a_occ)
  );
  tt_dfd_pipe_dff_clr #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00), .COLLAPSE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .in_data(b_in_data), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
    .out_data(b_out_data), .occ(b_occ)
  );
  tt_dfd_pipe_dff_clr #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00), .COLLAPSE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_vld(c_in_vld), .in_rdy(c_in_rdy),
    .in_data(c_in_data), .out_vld(c_out_vld), .out_rdy(c_out_rdy),
    .out_data(c_out_data), .occ(c_occ)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n || a_clr) a_q.delete();
    else begin
      if (a_out_vld && a_out_rdy) begin
        if (a_q.size() == 0) chk("a_extra_beat", 32'(a_q.size()), 1);
        else begin
          chk("a_order", 32'(a_out_data), 32'(a_q.pop_front()));
          a_pops++;
        end
      end
      if (a_in_vld && a_in_rdy) a_q.push_back(a_in_data);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [7:0] d, output int waits);
    a_in_vld = 1;
    a_in_data = d;
    waits = 0;
    @(negedge clk);
    while (!a_in_rdy && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) chk("a_push_timeout", 32'(waits), 0);
    step();
    a_in_vld = 0;
  endtask
  task automatic drain_a();
    int w = 0;
    a_out_rdy = 1;
    @(negedge clk);
    while ((a_q.size() != 0 || a_out_vld) && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("a_drain_q", 32'(a_q.size()), 0);
    chk("a_drain_occ", 32'(a_occ), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    int w;
    int p0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(a_out_data), 32'hA5);
    chk("rst_occ", 32'(a_occ), 0);
    chk("rst_vld", 32'(a_out_vld), 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_in_rdy", 32'(a_in_rdy), 1);
    step();
    a_out_rdy = 1;
    a_in_vld = 1;
    a_in_data = 8'h01;
    step();
    a_in_data = 8'h02;
    step();
    a_in_data = 8'h03;
    step();
    a_in_vld = 0;
    @(negedge clk);
    chk("lat_vld", 32'(a_out_vld), 1);
    chk("lat_d1", 32'(a_out_data), 32'h01);
    @(negedge clk);
    chk("lat_d2", 32'(a_out_data), 32'h02);
    @(negedge clk);
    chk("lat_d3", 32'(a_out_data), 32'h03);
    drain_a();
    step();
    a_out_rdy = 0;
    p0 = a_pops;
    push_a(8'h10, w);
    push_a(8'h11, w);
    push_a(8'h12, w);
    a_in_vld = 1;
    a_in_data = 8'h13;
    @(negedge clk);
    chk("bp_in_rdy", 32'(a_in_rdy), 0);
    chk("bp_occ", 32'(a_occ), 3);
    chk("bp_hold", 32'(a_out_data), 32'h10);
    step();
    a_out_rdy = 1;
    push_a(8'h13, w);
    chk("bp_full_accept", 32'(w), 0);
    drain_a();
    chk("bp_count", 32'(a_pops - p0), 4);
    step();
    a_out_rdy = 0;
    b_out_rdy = 0;
    a_in_vld = 1;
    a_in_data = 8'h20;
    b_in_vld = 1;
    b_in_data = 8'h20;
    step();
    a_in_vld = 0;
    b_in_vld = 0;
    @(negedge clk);
    chk("b_occ1", 32'(b_occ), 1);
    chk("b_vld_interior", 32'(b_out_vld), 0);
    step();
    step();
    a_in_vld = 1;
    a_in_data = 8'h21;
    b_in_vld = 1;
    b_in_data = 8'h21;
    @(negedge clk);
    chk("b_out_vld", 32'(b_out_vld), 1);
    chk("b_out_data", 32'(b_out_data), 32'h20);
    chk("b_stall_rdy", 32'(b_in_rdy), 0);
    step();
    a_in_vld = 0;
    @(negedge clk);
    chk("b_stall_occ", 32'(b_occ), 1);
    chk("b_stall_rdy2", 32'(b_in_rdy), 0);
    chk("col_occ", 32'(a_occ), 2);
    chk("col_in_rdy", 32'(a_in_rdy), 1);
    step();
    b_in_vld = 0;
    push_a(8'h22, w);
    chk("col_third", 32'(w), 0);
    drain_a();
    step();
    b_out_rdy = 1;
    @(negedge clk);
    chk("b_rdy_moving", 32'(b_in_rdy), 1);
    step();
    @(negedge clk);
    chk("b_drain_occ", 32'(b_occ), 0);
    chk("b_drain_vld", 32'(b_out_vld), 0);
    step();
    p0 = a_pops;
    a_out_rdy = 1;
    a_in_vld = 1;
    a_in_data = 8'h30;
    step();
    a_in_data = 8'h31;
    step();
    a_in_data = 8'h32;
    step();
    a_clr = 1;
    a_in_data = 8'h55;
    @(negedge clk);
    chk("clr_in_rdy", 32'(a_in_rdy), 0);
    chk("clr_out_vld", 32'(a_out_vld), 0);
    step();
    a_clr = 0;
    a_in_vld = 0;
    @(negedge clk);
    chk("clr_occ", 32'(a_occ), 0);
    chk("clr_vld", 32'(a_out_vld), 0);
    chk("clr_data", 32'(a_out_data), 32'hA5);
    repeat (5) @(negedge clk);
    chk("clr_no_emit", 32'(a_pops - p0), 0);
    step();
    a_out_rdy = 0;
    push_a(8'h40, w);
    push_a(8'h41, w);
    step();
    @(negedge clk);
    chk("ar_pre_occ", 32'(a_occ), 2);
    chk("ar_pre_vld", 32'(a_out_vld), 1);
    chk("ar_pre_data", 32'(a_out_data), 32'h40);
    #2 rst_n = 0;
    #1;
    chk("ar_vld", 32'(a_out_vld), 0);
    chk("ar_occ", 32'(a_occ), 0);
    chk("ar_data", 32'(a_out_data), 32'hA5);
    chk("ar_in_rdy", 32'(a_in_rdy), 1);
    @(negedge clk);
    #2 rst_n = 1;
    step();
    c_out_rdy = 0;
    c_in_vld = 1;
    c_in_data = 8'h7D;
    step();
    c_in_data = 8'h7E;
    @(negedge clk);
    chk("c_stall_rdy", 32'(c_in_rdy), 0);
    chk("c_occ", 32'(c_occ), 1);
    chk("c_hold", 32'(c_out_data), 32'h7D);
    #1 c_out_rdy = 1;
    #1 chk("c_pass_rdy", 32'(c_in_rdy), 1);
    step();
    c_in_vld = 0;
    c_out_rdy = 0;
    @(negedge clk);
    chk("c_data", 32'(c_out_data), 32'h7E);
    chk("c_occ_keep", 32'(c_occ), 1);
    chk("c_vld", 32'(c_out_vld), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
